axis_upsizer: RTL

Synthesizable AXI-Stream width upsizer. It packs R = M_WORDS/S_WORDS narrow input beats into one wide output beat. It sits between a narrow stream producer (the AXIS source model in benches) and a wide consumer (the AXIS sink model). Short final groups are flushed on s_last with m_keep marking the valid words. It sustains one input beat per cycle when the output is not back-pressured.

---
 rtl/axis_upsizer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/axis_upsizer.sv
// axis_upsizer: packs R narrow AXI-Stream beats into one wide beat.
// Short groups flush on s_last; m_keep marks the words that carry data.
module axis_upsizer #(
  parameter int WORD_W  = 8,
  parameter int S_WORDS = 1,
  parameter int M_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [S_WORDS-1:0][WORD_W-1:0]   s_data,
  input  logic                             s_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [M_WORDS-1:0][WORD_W-1:0]   m_data,
  output logic [M_WORDS-1:0]               m_keep,
  output logic                             m_last
);

  localparam int R  = M_WORDS / S_WORDS;
  localparam int SB = S_WORDS * WORD_W;
  localparam int CW = (R > 1) ? $clog2(R) : 1;

  // accumulator and group bookkeeping
  logic [R-1:0][SB-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 acc_last_q, acc_last_d;
  logic                 pend_q, pend_d;
  logic [R-1:0]         pslots_q, pslots_d;
  logic                 run_q, run_d;

  // output register
  logic [R-1:0][SB-1:0] m_data_q, m_data_d;
  logic [M_WORDS-1:0]   m_keep_q, m_keep_d;
  logic                 m_last_q, m_last_d;
  logic                 m_valid_q, m_valid_d;

  // handshake and group-completion terms
  logic s_hs;
  logic m_hs;
  logic out_free;
  logic cnt_end;
  logic done;

  // merged views of the current and the pending group
  logic [R-1:0]         g_slots;
  logic [R-1:0][SB-1:0] g_data;
  logic [M_WORDS-1:0]   g_keep;
  logic [R-1:0][SB-1:0] p_data;
  logic [M_WORDS-1:0]   p_keep;

  assign s_ready  = run_q && !pend_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_keep   = m_keep_q;
  assign m_last   = m_last_q;

  assign s_hs     = s_valid && s_ready;
  assign m_hs     = m_valid_q && m_ready;
  assign out_free = !m_valid_q || m_ready;
  assign cnt_end  = (cnt_q == CW'(R - 1));
  assign done     = s_hs && (cnt_end || s_last);

  // build masked group data: live beat in slot cnt, zeros above it
  always_comb begin
    g_slots = '0;
    g_data  = '0;
    g_keep  = '0;
    p_data  = '0;
    p_keep  = '0;
    for (int i = 0; i < R; i++) begin
      g_slots[i] = (CW'(i) <= cnt_q);
      if (g_slots[i]) begin
        if (CW'(i) == cnt_q) begin
          g_data[i] = s_data;
        end else begin
          g_data[i] = acc_q[i];
        end
      end
      if (pslots_q[i]) begin
        p_data[i] = acc_q[i];
      end
      g_keep[i*S_WORDS +: S_WORDS] = {S_WORDS{g_slots[i]}};
      p_keep[i*S_WORDS +: S_WORDS] = {S_WORDS{pslots_q[i]}};
    end
  end

  // next-state: pending drain, group completion, or plain accumulate
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    acc_last_d = acc_last_q;
    pend_d     = pend_q;
    pslots_d   = pslots_q;
    run_d      = 1'b1;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q;
    unique case (1'b1)
      pend_q: begin
        if (out_free) begin
          m_data_d  = p_data;
          m_keep_d  = p_keep;
          m_last_d  = acc_last_q;
          m_valid_d = 1'b1;
          pend_d    = 1'b0;
        end
      end
      done: begin
        cnt_d = '0;
        if (out_free) begin
          m_data_d  = g_data;
          m_keep_d  = g_keep;
          m_last_d  = s_last;
          m_valid_d = 1'b1;
        end else begin
          for (int i = 0; i < R; i++) begin
            if (CW'(i) == cnt_q) begin
              acc_d[i] = s_data;
            end
          end
          acc_last_d = s_last;
          pslots_d   = g_slots;
          pend_d     = 1'b1;
        end
      end
      default: begin
        if (s_hs) begin
          for (int i = 0; i < R; i++) begin
            if (CW'(i) == cnt_q) begin
              acc_d[i] = s_data;
            end
          end
          cnt_d = cnt_q + CW'(1);
        end
        if (m_hs) begin
          m_valid_d = 1'b0;
        end
      end
    endcase
  end

  // state registers; reset drops any partial group
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      acc_last_q <= 1'b0;
      pend_q     <= 1'b0;
      pslots_q   <= '0;
      run_q      <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      acc_last_q <= acc_last_d;
      pend_q     <= pend_d;
      pslots_q   <= pslots_d;
      run_q      <= run_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_last_q   <= m_last_d;
      m_valid_q  <= m_valid_d;
    end
  end

endmodule
